// File: rtl/booth_r4_seq_mult.sv
// Sequential signed multiplier using radix-4 Booth recoding.
// Retires one recoded digit per clock through a single add/sub step and reports completion with a busy/done handshake.
module booth_r4_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int unsigned ACC_W  = WIDTH + 2;
    localparam int unsigned ITER   = WIDTH / 2;
    localparam int unsigned CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state_q,   state_d;
    logic [ACC_W-1:0]    acc_q,     acc_d;
    logic [ACC_W-1:0]    m_q,       m_d;
    logic [WIDTH-1:0]    q_q,       q_d;
    logic                qm1_q,     qm1_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [PROD_W-1:0]   product_q, product_d;

    logic [2:0]          digit;
    logic [ACC_W-1:0]    step_b;
    logic                step_sub;
    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    acc_shift;
    logic [WIDTH-1:0]    q_shift;
    logic                qm1_shift;

    // Booth digit decode and the shared add/sub step (sub: A + ~B + 1)
    always_comb begin
        digit    = {q_q[1:0], qm1_q};
        step_b   = '0;
        step_sub = 1'b0;
        case (digit)
            3'b001, 3'b010: step_b = m_q;
            3'b011:         step_b = {m_q[ACC_W-2:0], 1'b0};
            3'b100: begin
                step_b   = {m_q[ACC_W-2:0], 1'b0};
                step_sub = 1'b1;
            end
            3'b101, 3'b110: begin
                step_b   = m_q;
                step_sub = 1'b1;
            end
            default: begin
                step_b   = '0;
                step_sub = 1'b0;
            end
        endcase
        acc_sum = acc_q + (step_b ^ {ACC_W{step_sub}}) + ACC_W'(step_sub);
    end

    // Arithmetic shift of {ACC, Q, q_m1} right by two
    always_comb begin
        acc_shift = {{2{acc_sum[ACC_W-1]}}, acc_sum[ACC_W-1:2]};
        q_shift   = {acc_sum[1:0], q_q[WIDTH-1:2]};
        qm1_shift = q_q[1];
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    m_d     = {{2{i_a[WIDTH-1]}}, i_a};
                    acc_d   = '0;
                    q_d     = i_b;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_shift;
                q_d   = q_shift;
                qm1_d = qm1_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    product_d = {acc_shift[WIDTH-1:0], q_shift};
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset wins over any start request in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_product = product_q;

endmodule
